// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI scan-out controller: register map,
// CTRL/STATUS bit positions, counter width and the raster timing helper.
package hdmi_pkg;

  // Raster counters are 12 bits so the line number fits STATUS[27:16].
  localparam int CNT_W = 12;

  // APB register word offsets (byte address bits [7:2]).
  localparam logic [5:0] REG_CTRL    = 6'h00;
  localparam logic [5:0] REG_STATUS  = 6'h01;
  localparam logic [5:0] REG_FB_LO   = 6'h02;
  localparam logic [5:0] REG_FB_HI   = 6'h03;
  localparam logic [5:0] REG_STRIDE  = 6'h04;

  // CTRL bit positions.
  localparam int CTRL_EN = 0;
  localparam int CTRL_IE = 1;

  // STATUS bit positions.
  localparam int ST_VBLANK    = 0;
  localparam int ST_IRQ       = 1;
  localparam int ST_UNDERFLOW = 2;
  localparam int ST_REQ_DROP  = 3;

  // Total pixels per line or lines per frame from the four timing segments.
  function automatic int frame_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/hdmi_if.sv
// Bus bundle of the scan-out controller: APB register port, line-fetch
// request channel and pixel stream from the line FIFO.
interface hdmi_if #(
  parameter int AW = 36
);
  // APB
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [7:0]    paddr;
  logic [31:0]   pwdata;
  logic [31:0]   prdata;
  logic          pready;
  // Line-fetch request
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  // Pixel stream
  logic          pix_valid;
  logic          pix_ready;
  logic [31:0]   pix_data;

  // Controller side: APB slave, request source, pixel sink.
  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready,
    output req_valid, req_addr,
    input  req_ready,
    input  pix_valid, pix_data,
    output pix_ready
  );

  // System side: APB master, request sink, pixel source.
  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready,
    input  req_valid, req_addr,
    output req_ready,
    output pix_valid, pix_data,
    input  pix_ready
  );

endinterface

// File: rtl/hdmi_timing_gen.sv
// Raster timing generator: horizontal/vertical counters plus registered
// HSYNC/VSYNC/DE decode. Counters park at (0,0) whenever en is low.
module hdmi_timing_gen
  import hdmi_pkg::*;
#(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             de_int,
  output logic             hsync,
  output logic             vsync,
  output logic             de
);

  localparam int H_TOTAL = frame_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = frame_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] h_cnt_r;
  logic [CNT_W-1:0] v_cnt_r;
  logic             hs_win_s;
  logic             vs_win_s;

  // Raster counters: one pixel per clock while enabled, held at the origin otherwise.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      h_cnt_r <= '0;
      v_cnt_r <= '0;
    end else if (h_cnt_r == H_LAST) begin
      h_cnt_r <= '0;
      if (v_cnt_r == V_LAST) begin
        v_cnt_r <= '0;
      end else begin
        v_cnt_r <= v_cnt_r + CNT_ONE;
      end
    end else begin
      h_cnt_r <= h_cnt_r + CNT_ONE;
      v_cnt_r <= v_cnt_r;
    end
  end

  // Unregistered decode of the current counter state into active and sync windows.
  always_comb begin
    de_int   = en && (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
    hs_win_s = (h_cnt_r >= HS_START) && (h_cnt_r < HS_END);
    vs_win_s = (v_cnt_r >= VS_START) && (v_cnt_r < VS_END);
  end

  // Registered video timing outputs, idle while disabled.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      de    <= 1'b0;
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
    end else begin
      de    <= de_int;
      hsync <= hs_win_s ? SYNC_POL : ~SYNC_POL;
      vsync <= vs_win_s ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign h_cnt = h_cnt_r;
  assign v_cnt = v_cnt_r;

endmodule

// File: rtl/hdmi_ctrl.sv
// HDMI scan-out controller top: APB register file, per-line fetch request
// generation with per-frame base shadowing, pixel mux and vblank interrupt.
module hdmi_ctrl
  import hdmi_pkg::*;
#(
  parameter int   M_AXI_ADDR_WIDTH = 36,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  hdmi_if.slave       bus,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [23:0] rgb,
  output logic        intr
);

  localparam int AW      = M_AXI_ADDR_WIDTH;
  localparam int V_TOTAL = frame_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Registers
  logic           en_r, ie_r;
  logic           irq_pend_r, underflow_r, req_drop_r;
  logic [31:0]    fb_lo_r;
  logic [AW-33:0] fb_hi_r;
  logic [31:0]    stride_r;
  logic [AW-1:0]  fb_shadow_r;
  logic           req_valid_r;
  logic [AW-1:0]  req_addr_r;
  logic [23:0]    rgb_r;
  logic           intr_r;

  // Combinational
  logic             wr_s, wr_ctrl_s, wr_status_s;
  logic             en_eff_s;
  logic [CNT_W-1:0] h_cnt_s, v_cnt_s, next_line_s;
  logic             de_int_s;
  logic             req_point_s, irq_set_s, underflow_set_s;
  logic [AW-1:0]    fb_full_s, req_addr_nxt_s;
  logic             irq_pend_nxt_s, underflow_nxt_s, req_drop_nxt_s, ie_nxt_s;
  logic [31:0]      prdata_s;
  logic             unused_s;

  assign wr_s        = bus.psel & bus.penable & bus.pwrite;
  assign wr_ctrl_s   = wr_s && (bus.paddr[7:2] == REG_CTRL);
  assign wr_status_s = wr_s && (bus.paddr[7:2] == REG_STATUS);
  // A write clearing EN stops the raster and fetch on that same edge.
  assign en_eff_s    = en_r & ~(wr_ctrl_s & ~bus.pwdata[CTRL_EN]);
  assign unused_s    = ^{bus.paddr[1:0], bus.pix_data[31:24]};

  hdmi_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clk    (clk),
    .rst    (rst),
    .en     (en_eff_s),
    .h_cnt  (h_cnt_s),
    .v_cnt  (v_cnt_s),
    .de_int (de_int_s),
    .hsync  (hsync),
    .vsync  (vsync),
    .de     (de)
  );

  // Event decode: fetch request point, interrupt point, underflow and next flag values.
  always_comb begin
    next_line_s     = (v_cnt_s == V_LAST) ? '0 : (v_cnt_s + CNT_ONE);
    req_point_s     = en_eff_s && (h_cnt_s == H_ACT) && (next_line_s < V_ACT);
    irq_set_s       = en_eff_s && (v_cnt_s == V_ACT) && (h_cnt_s == '0);
    underflow_set_s = de_int_s && !bus.pix_valid;
    fb_full_s       = {fb_hi_r, fb_lo_r};
    // Line 0 of a frame uses the live base, which is latched into the shadow at that point.
    if (next_line_s == '0) begin
      req_addr_nxt_s = fb_full_s;
    end else begin
      req_addr_nxt_s = fb_shadow_r + (AW'(next_line_s) * AW'(stride_r));
    end
    // Hardware set beats a same-cycle W1C clear.
    if (irq_set_s) begin
      irq_pend_nxt_s = 1'b1;
    end else if (wr_status_s && bus.pwdata[ST_IRQ]) begin
      irq_pend_nxt_s = 1'b0;
    end else begin
      irq_pend_nxt_s = irq_pend_r;
    end
    if (underflow_set_s) begin
      underflow_nxt_s = 1'b1;
    end else if (wr_status_s && bus.pwdata[ST_UNDERFLOW]) begin
      underflow_nxt_s = 1'b0;
    end else begin
      underflow_nxt_s = underflow_r;
    end
    if (req_point_s && req_valid_r && !bus.req_ready) begin
      req_drop_nxt_s = 1'b1;
    end else if (wr_status_s && bus.pwdata[ST_REQ_DROP]) begin
      req_drop_nxt_s = 1'b0;
    end else begin
      req_drop_nxt_s = req_drop_r;
    end
    ie_nxt_s = wr_ctrl_s ? bus.pwdata[CTRL_IE] : ie_r;
  end

  // APB-visible registers and sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_r        <= 1'b0;
      ie_r        <= 1'b0;
      irq_pend_r  <= 1'b0;
      underflow_r <= 1'b0;
      req_drop_r  <= 1'b0;
      fb_lo_r     <= 32'h0000_0000;
      fb_hi_r     <= '0;
      stride_r    <= 32'h0000_0000;
      intr_r      <= 1'b0;
    end else begin
      en_r        <= wr_ctrl_s ? bus.pwdata[CTRL_EN] : en_r;
      ie_r        <= ie_nxt_s;
      irq_pend_r  <= irq_pend_nxt_s;
      underflow_r <= underflow_nxt_s;
      req_drop_r  <= req_drop_nxt_s;
      if (wr_s && (bus.paddr[7:2] == REG_FB_LO)) fb_lo_r <= bus.pwdata;
      if (wr_s && (bus.paddr[7:2] == REG_FB_HI)) fb_hi_r <= bus.pwdata[AW-33:0];
      if (wr_s && (bus.paddr[7:2] == REG_STRIDE)) stride_r <= bus.pwdata;
      intr_r      <= irq_pend_nxt_s & ie_nxt_s;
    end
  end

  // Line-fetch request channel; a new request point overwrites any pending one.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_valid_r <= 1'b0;
      req_addr_r  <= '0;
      fb_shadow_r <= '0;
    end else if (!en_eff_s) begin
      req_valid_r <= 1'b0;
    end else if (req_point_s) begin
      req_valid_r <= 1'b1;
      req_addr_r  <= req_addr_nxt_s;
      if (next_line_s == '0) fb_shadow_r <= fb_full_s;
    end else if (req_valid_r && bus.req_ready) begin
      req_valid_r <= 1'b0;
    end
  end

  // Pixel mux: FIFO data during active video, black on underflow or blanking.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_r <= 24'h00_0000;
    end else if (de_int_s && bus.pix_valid) begin
      rgb_r <= bus.pix_data[23:0];
    end else begin
      rgb_r <= 24'h00_0000;
    end
  end

  // APB read mux; unmapped offsets read as zero.
  always_comb begin
    prdata_s = 32'h0000_0000;
    case (bus.paddr[7:2])
      REG_CTRL:   prdata_s = {30'h0, ie_r, en_r};
      REG_STATUS: prdata_s = {4'h0, v_cnt_s, 12'h000, req_drop_r, underflow_r,
                              irq_pend_r, (v_cnt_s >= V_ACT)};
      REG_FB_LO:  prdata_s = fb_lo_r;
      REG_FB_HI:  prdata_s = 32'(fb_hi_r);
      REG_STRIDE: prdata_s = stride_r;
      default:    prdata_s = 32'h0000_0000;
    endcase
  end

  assign bus.prdata    = prdata_s;
  assign bus.pready    = 1'b1;
  assign bus.req_valid = req_valid_r;
  assign bus.req_addr  = req_addr_r;
  assign bus.pix_ready = de_int_s;
  assign rgb           = rgb_r;
  assign intr          = intr_r;

endmodule

// File: tb/tb_hdmi_ctrl.sv
// Directed bench for hdmi_ctrl using a reduced raster
// (H 8/2/2/2 -> 14 pixels, V 4/1/1/1 -> 7 lines, 98 cycles per frame).
module tb_hdmi_ctrl;

  logic        clk;
  logic        rst;
  logic        hsync, vsync, de, intr;
  logic [23:0] rgb;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  hdmi_if #(.AW(36)) bus ();

  hdmi_ctrl #(
    .M_AXI_ADDR_WIDTH (36),
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .SYNC_POL (1'b0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .hsync (hsync),
    .vsync (vsync),
    .de    (de),
    .rgb   (rgb),
    .intr  (intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
    bus.psel = 1'b1; bus.pwrite = 1'b1; bus.penable = 1'b0;
    bus.paddr = a; bus.pwdata = d;
    tick();
    bus.penable = 1'b1;
    tick();
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [7:0] a, output logic [31:0] d);
    bus.paddr = a;
    #1;
    d = bus.prdata;
  endtask

  // Stop, clear all sticky flags, start again at raster (0,0); cyc counts from there.
  task automatic restart(input logic [31:0] ctrl);
    apb_wr(8'h00, 32'h0);
    apb_wr(8'h04, 32'hE);
    apb_wr(8'h00, ctrl);
    cyc = 0;
  endtask

  logic [31:0] rd;

  initial begin
    rst = 1'b1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = 8'h00; bus.pwdata = 32'h0;
    bus.req_ready = 1'b1;
    bus.pix_valid = 1'b1; bus.pix_data = 32'hAB12_3456;
    tick(); tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_de", 64'(de), 64'h0);
    chk("rst_hsync", 64'(hsync), 64'h1);
    chk("rst_vsync", 64'(vsync), 64'h1);
    chk("rst_rgb", 64'(rgb), 64'h0);
    chk("rst_intr", 64'(intr), 64'h0);
    chk("rst_req_valid", 64'(bus.req_valid), 64'h0);
    chk("pready", 64'(bus.pready), 64'h1);
    apb_rd(8'h00, rd); chk("rst_ctrl", 64'(rd), 64'h0);
    apb_rd(8'h04, rd); chk("rst_status", 64'(rd), 64'h0);

    // Register file: FB_HI masked to 4 bits, unmapped reads 0
    apb_wr(8'h08, 32'h0000_0000);
    apb_wr(8'h0C, 32'hFFFF_FFF1);
    apb_wr(8'h10, 32'h0000_0040);
    apb_wr(8'h20, 32'hFFFF_FFFF);
    apb_rd(8'h0C, rd); chk("fb_hi_rd", 64'(rd), 64'h1);
    apb_rd(8'h10, rd); chk("stride_rd", 64'(rd), 64'h40);
    apb_rd(8'h20, rd); chk("unmapped_rd", 64'(rd), 64'h0);

    // Two full frames against a raster model; first frame runs on the reset shadow
    restart(32'h1);
    for (int k = 1; k <= 196; k++) begin
      int s, h, v, f, n, hn, vn;
      logic e_de, e_req;
      logic [35:0] e_addr;
      tick();
      s = k - 1; h = s % 14; v = (s / 14) % 7; f = s / 98;
      n = (v == 6) ? 0 : v + 1;
      e_de = (h < 8) && (v < 4);
      chk("de", 64'(de), 64'(e_de));
      chk("hsync", 64'(hsync), 64'(!(h >= 10 && h < 12)));
      chk("vsync", 64'(vsync), 64'(v != 5));
      chk("rgb", 64'(rgb), e_de ? 64'h12_3456 : 64'h0);
      e_req = (h == 8) && (n < 4);
      chk("req_valid", 64'(bus.req_valid), 64'(e_req));
      if (e_req) begin
        e_addr = ((f == 0 && n != 0) ? 36'h0_0000_0000 : 36'h1_0000_0000) + 36'(n) * 36'h40;
        chk("req_addr", 64'(bus.req_addr), 64'(e_addr));
      end
      hn = k % 14; vn = (k / 14) % 7;
      chk("pix_ready", 64'(bus.pix_ready), 64'((hn < 8) && (vn < 4)));
    end
    apb_rd(8'h04, rd); chk("frame_status", 64'(rd), 64'h2);

    // Request drop with REQ_READY low, underflow on line 1
    bus.req_ready = 1'b0;
    restart(32'h1);
    wait_to(9);
    chk("drop_valid1", 64'(bus.req_valid), 64'h1);
    chk("drop_addr1", 64'(bus.req_addr), 64'h1_0000_0040);
    apb_rd(8'h04, rd); chk("drop_status0", 64'(rd), 64'h0);
    wait_to(14); bus.pix_valid = 1'b0;
    wait_to(15);
    chk("uf_de", 64'(de), 64'h1);
    chk("uf_rgb", 64'(rgb), 64'h0);
    wait_to(22);
    chk("uf_rgb_last", 64'(rgb), 64'h0);
    chk("drop_hold_addr", 64'(bus.req_addr), 64'h1_0000_0040);
    bus.pix_valid = 1'b1;
    wait_to(23);
    chk("drop_valid2", 64'(bus.req_valid), 64'h1);
    chk("drop_addr2", 64'(bus.req_addr), 64'h1_0000_0080);
    apb_rd(8'h04, rd); chk("drop_uf_status", 64'(rd), 64'h0001_000C);
    bus.req_ready = 1'b1;
    wait_to(24);
    chk("drop_accept", 64'(bus.req_valid), 64'h0);
    apb_wr(8'h04, 32'hC);
    apb_rd(8'h04, rd); chk("w1c_status", 64'(rd), 64'h0001_0000);

    // EN cleared mid-line, then re-enable restarts at (0,0)
    bus.req_ready = 1'b0;
    restart(32'h1);
    wait_to(15);
    chk("dis_de_before", 64'(de), 64'h1);
    chk("dis_req_before", 64'(bus.req_valid), 64'h1);
    apb_wr(8'h00, 32'h0);
    chk("dis_de", 64'(de), 64'h0);
    chk("dis_req", 64'(bus.req_valid), 64'h0);
    apb_wr(8'h00, 32'h1);
    cyc = 0;
    apb_rd(8'h04, rd); chk("reen_status", 64'(rd), 64'h0);
    wait_to(1); chk("reen_de", 64'(de), 64'h1);
    wait_to(8); chk("reen_req_early", 64'(bus.req_valid), 64'h0);
    wait_to(9);
    chk("reen_req", 64'(bus.req_valid), 64'h1);
    chk("reen_addr", 64'(bus.req_addr), 64'h1_0000_0040);

    // Interrupt with IE=1: rise at (4,0), W1C, next frame, set-beats-clear
    bus.req_ready = 1'b1;
    restart(32'h3);
    chk("irq_start", 64'(intr), 64'h0);
    wait_to(56); chk("irq_pre", 64'(intr), 64'h0);
    wait_to(57);
    chk("irq_rise", 64'(intr), 64'h1);
    chk("irq_de", 64'(de), 64'h0);
    apb_rd(8'h04, rd); chk("irq_status", 64'(rd), 64'h0004_0003);
    apb_wr(8'h04, 32'h2);
    chk("irq_w1c", 64'(intr), 64'h0);
    wait_to(154); chk("irq_pre2", 64'(intr), 64'h0);
    wait_to(155); chk("irq_rise2", 64'(intr), 64'h1);
    apb_wr(8'h04, 32'h2);
    chk("irq_w1c2", 64'(intr), 64'h0);
    wait_to(251);
    apb_wr(8'h04, 32'h2);
    chk("irq_set_wins", 64'(intr), 64'h1);
    apb_rd(8'h04, rd); chk("irq_set_wins_st", 64'(rd), 64'h0004_0003);

    // Reset mid-operation
    wait_to(295);
    chk("pre_rst_de", 64'(de), 64'h1);
    chk("pre_rst_intr", 64'(intr), 64'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_de", 64'(de), 64'h0);
    chk("mid_rst_intr", 64'(intr), 64'h0);
    chk("mid_rst_hsync", 64'(hsync), 64'h1);
    chk("mid_rst_req", 64'(bus.req_valid), 64'h0);
    apb_rd(8'h00, rd); chk("mid_rst_ctrl", 64'(rd), 64'h0);
    apb_rd(8'h04, rd); chk("mid_rst_status", 64'(rd), 64'h0);
    apb_rd(8'h0C, rd); chk("mid_rst_fb_hi", 64'(rd), 64'h0);
    apb_rd(8'h10, rd); chk("mid_rst_stride", 64'(rd), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
